rr_arbiter_8: RTL and testbench

- Round-robin arbiter that shares one resource (bus or chip-select) among up to 8 requesters.
- Picks one winner per grant period and drives a one-hot grant vector decoded from the winner's index. The index is also output directly.
- Sits between the requesting masters and the downstream select/decode datapath.
- Grants are held until the owner releases them. An optional hold timeout forces release.

---
 rtl/arb_pkg.sv | 6 +
 rtl/onehot_dec.sv | 10 +
 rtl/rr_arbiter_8.sv | 95 +++++++++
 tb/tb_rr_arbiter_8.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared state encoding and default sizing for the round-robin arbiter.
package arb_pkg;
   typedef enum logic {IDLE, GRANT} arb_state_t;
   localparam int ARB_N_REQ_DEFAULT    = 8;
   localparam int ARB_MAX_HOLD_DEFAULT = 16;
endpackage

// File: rtl/onehot_dec.sv
// onehot_dec: index to one-hot decoder.
module onehot_dec #(
   parameter int N_REQ = 8,
   parameter int IDX_W = 3
) (
   input  logic [IDX_W-1:0] i_idx,
   output logic [N_REQ-1:0] o_onehot
);
   assign o_onehot = N_REQ'(1) << i_idx;
endmodule

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: round-robin arbiter with owner-held grants.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD cycles of ownership.
module rr_arbiter_8
   import arb_pkg::*;
#(
   parameter int N_REQ    = ARB_N_REQ_DEFAULT,
   parameter int MAX_HOLD = ARB_MAX_HOLD_DEFAULT,
   localparam int IDX_W   = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] done,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             timeout
);
   arb_state_t       r_state;
   logic [N_REQ-1:0] r_gnt;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] r_ptr;
   logic             r_valid;
   logic             r_timeout;
   logic             w_own_rel;
   logic             w_force;
   logic             w_release;
   logic             w_found;
   logic [IDX_W-1:0] w_start;
   logic [IDX_W-1:0] w_win;
   logic [N_REQ-1:0] w_cand;
   logic [N_REQ-1:0] w_dec;

   if (N_REQ < 2 || N_REQ > 16 || (N_REQ & (N_REQ - 1)) != 0 || MAX_HOLD < 2) begin : g_bad_params
      $error("rr_arbiter_8: invalid N_REQ or MAX_HOLD");
   end

   assign w_own_rel = done[r_idx] | ~req[r_idx];

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(MAX_HOLD);
   logic [CNT_W-1:0] r_cnt;
   assign w_force = (r_state == GRANT) && !w_own_rel && (r_cnt == CNT_W'(MAX_HOLD - 1));
   // A forced release always fires at MAX_HOLD-1, so the count never needs to climb past it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_cnt <= '0;
      else r_cnt <= (r_state != GRANT || w_release) ? '0 : r_cnt + 1'b1;
   end
`else
   assign w_force = 1'b0;
`endif

   assign w_release = (r_state == GRANT) && (w_own_rel || w_force);
   // Scan starts just past the owner so the releasing index has lowest priority
   assign w_start = (r_state == GRANT) ? r_idx + 1'b1 : r_ptr;
   assign w_cand  = req & ~((r_state == GRANT) ? r_gnt : '0);

   always_comb begin
      w_found = 1'b0;
      w_win   = w_start;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (w_cand[w_start + IDX_W'(i)]) begin
            w_found = 1'b1;
            w_win   = w_start + IDX_W'(i);
         end
      end
   end

   onehot_dec #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_dec (.i_idx(w_win), .o_onehot(w_dec));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_gnt     <= '0;
         r_idx     <= '0;
         r_ptr     <= '0;
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_force;
         if (r_state == IDLE || w_release) begin
            if (w_release) r_ptr <= r_idx + 1'b1;
            r_state <= w_found ? GRANT : IDLE;
            r_gnt   <= w_found ? w_dec : '0;
            r_idx   <= w_found ? w_win : '0;
            r_valid <= w_found;
         end
      end
   end

   assign gnt       = r_gnt;
   assign gnt_idx   = r_idx;
   assign gnt_valid = r_valid;
   assign timeout   = r_timeout;
endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: directed and random stimulus against a queue-free round-robin reference model.
module tb_rr_arbiter_8;
   localparam int N    = 8;
   localparam int MAXH = 16;
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] req = '0;
   logic [N-1:0] done = '0;
   logic [N-1:0] gnt;
   logic [2:0]   gnt_idx;
   logic         gnt_valid;
   logic         timeout;

   int checks = 0;
   int errors = 0;
   int m_owner = -1;
   int m_ptr = 0;
   int m_hold = 0;
   bit m_to = 1'b0;

   rr_arbiter_8 dut (
      .clk(clk), .rst_n(rst_n), .req(req), .done(done),
      .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // First requester at or after start (circularly), skipping excl
   function automatic int pick(input logic [N-1:0] r, input int start, input int excl);
      for (int k = 0; k < N; k++) begin
         int j;
         j = (start + k) % N;
         if (r[j] && j != excl) return j;
      end
      return -1;
   endfunction

   task automatic model_edge();
      bit rel;
      bit forced;
      m_to = 1'b0;
      if (m_owner < 0) begin
         m_owner = pick(req, m_ptr, -1);
         m_hold  = 0;
      end else begin
         rel    = done[m_owner] || !req[m_owner];
         forced = TO_EN && !rel && m_hold == MAXH - 1;
         if (rel || forced) begin
            m_to    = forced;
            m_ptr   = (m_owner + 1) % N;
            m_owner = pick(req, m_ptr, m_owner);
            m_hold  = 0;
         end else if (m_hold < MAXH - 1) m_hold++;
      end
   endtask

   task automatic check_outs(input string tag);
      chk({tag, ".gnt"}, 32'(gnt), (m_owner < 0) ? 32'd0 : 32'd1 << m_owner);
      chk({tag, ".idx"}, 32'(gnt_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
      chk({tag, ".valid"}, 32'(gnt_valid), 32'(m_owner >= 0));
      chk({tag, ".timeout"}, 32'(timeout), 32'(m_to));
   endtask

   task automatic step(input logic [N-1:0] r, input logic [N-1:0] d, input string tag);
      @(negedge clk);
      req  = r;
      done = d;
      @(posedge clk);
      model_edge();
      #1;
      check_outs(tag);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_outs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Fairness: every requester asks, owner releases one cycle after its grant
      step(8'hFF, 8'h00, "rr_first");
      chk("rr_first_idx", 32'(gnt_idx), 32'd0);
      for (int k = 1; k <= 8; k++) begin
         step(8'hFF, 8'(1 << m_owner), "rr");
         chk("rr_order", 32'(gnt_idx), 32'(k % 8));
         chk("rr_no_bubble", 32'(gnt_valid), 32'd1);
      end
      step(8'h00, 8'h00, "rr_drain");

      // Single requester
      step(8'h20, 8'h00, "single");
      chk("single_gnt", 32'(gnt), 32'h20);
      chk("single_idx", 32'(gnt_idx), 32'd5);
      repeat (2) step(8'h20, 8'h00, "single_hold");
      step(8'h00, 8'h20, "single_rel");
      chk("single_rel_gnt", 32'(gnt), 32'h00);

      // Wrap-around: owner 7 releases while re-requesting; 0 wins
      step(8'h80, 8'h00, "wrap_own");
      chk("wrap_own_idx", 32'(gnt_idx), 32'd7);
      step(8'h81, 8'h80, "wrap");
      chk("wrap_gnt", 32'(gnt), 32'h01);
      step(8'h00, 8'h00, "wrap_drain");

      // Foreign done and new requests do not preempt
      step(8'h04, 8'h00, "ign_own");
      step(8'h14, 8'h10, "ign");
      chk("ign_gnt", 32'(gnt), 32'h04);
      step(8'h14, 8'h00, "ign2");
      chk("ign2_gnt", 32'(gnt), 32'h04);
      step(8'h00, 8'h00, "ign_drain");

      // Asynchronous reset mid-grant
      step(8'h08, 8'h00, "rst_own");
      chk("rst_own_gnt", 32'(gnt), 32'h08);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      req   = '0;
      done  = '0;
      #1;
      chk("async_rst_gnt", 32'(gnt), 32'h00);
      chk("async_rst_idx", 32'(gnt_idx), 32'd0);
      chk("async_rst_valid", 32'(gnt_valid), 32'd0);
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
      m_to    = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(8'h08, 8'h00, "post_rst");
      chk("post_rst_gnt", 32'(gnt), 32'h08);
      step(8'h00, 8'h00, "post_rst_drain");

      // Long hold: owner 0 never releases
      for (int k = 0; k < 100; k++) step(8'h03, 8'h00, "hold");
      if (!TO_EN) begin
         chk("hold_gnt", 32'(gnt), 32'h01);
         chk("hold_timeout", 32'(timeout), 32'd0);
      end
      step(8'h00, 8'h00, "hold_drain");

      // Random traffic, done often aimed at the owner
      for (int k = 0; k < 600; k++) begin
         logic [N-1:0] r;
         logic [N-1:0] d;
         r = 8'($urandom);
         if ($urandom_range(3) == 0) r = r | 8'hF0;
         d = 8'($urandom) & 8'($urandom);
         if (m_owner >= 0 && $urandom_range(3) == 0) d = 8'(1 << m_owner);
         if (m_owner >= 0 && $urandom_range(1) == 0) r[m_owner] = 1'b1;
         step(r, d, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
